fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 5 +
 rtl/fifo_rd_stream_sat_counter.sv | 16 +
 rtl/fifo_rd_stream.sv | 66 ++++++
 tb/tb_fifo_rd_stream.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared occupancy states and skid depth for the FIFO read-side stream
package fifo_rd_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/fifo_rd_stream_sat_counter.sv
// sat_counter: saturating event counter; clr wins over inc; ports clk, reset_n, inc, clr, cnt
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO pop/empty/rdata to valid/ready stream via 2-entry skid, with pop/stall counters
// ports: clk, reset_n, en, empty, rdata -> pop; out_valid/out_ready/out_data stream; stat_clr, pop_cnt, stall_cnt
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] rdata,
    output logic              pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  pop_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] skid_q [SKID_DEPTH];
    logic [DATA_W-1:0] skid_d [SKID_DEPTH];
    logic              accept;
    // pop looks only at registered occupancy, so out_ready never reaches the FIFO combinationally
    assign pop       = reset_n & en & ~empty & (state_q != ST_TWO);
    assign out_valid = state_q != ST_EMPTY;
    assign out_data  = skid_q[0];
    assign accept    = out_valid & out_ready;
    always_comb begin
        state_d = state_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: if (pop) begin
                state_d   = ST_ONE;
                skid_d[0] = rdata;
            end
            ST_ONE: if (pop && accept) skid_d[0] = rdata;
                else if (pop) begin
                    state_d   = ST_TWO;
                    skid_d[1] = rdata;
                end
                else if (accept) state_d = ST_EMPTY;
            ST_TWO: if (accept) begin
                state_d   = ST_ONE;
                skid_d[0] = skid_q[1];
            end
            default: state_d = ST_EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            skid_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
        end
    sat_counter #(.CNT_W(CNT_W)) u_pop_cnt (
        .clk(clk), .reset_n(reset_n), .inc(pop), .clr(stat_clr), .cnt(pop_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset_n(reset_n), .inc(out_valid & ~out_ready), .clr(stat_clr), .cnt(stall_cnt)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vector table, corner sequences and queue scoreboard for fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int CW = 4;
    logic          clk = 0;
    logic          reset_n = 0;
    logic          en = 0, empty = 1, out_ready = 0, stat_clr = 0;
    logic [DW-1:0] rdata = '0;
    logic          pop, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] pop_cnt, stall_cnt;
    int            passed = 0, total = 0;

    fifo_rd_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .empty(empty), .rdata(rdata),
        .pop(pop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stat_clr(stat_clr), .pop_cnt(pop_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, empty;
        logic [DW-1:0] rdata;
        logic          rdy, clr;
        logic          pop, v;
        logic [DW-1:0] d;
        logic [CW-1:0] pc, sc;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic e, input logic em, input logic [DW-1:0] rd, input logic r, input logic c);
        @(negedge clk);
        en = e; empty = em; rdata = rd; out_ready = r; stat_clr = c;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 8'hA5, 1, 0, 1, 1, 8'hA5, 1, 0};
        vecs[1]  = '{1, 1, 8'h00, 1, 0, 0, 0, 8'hA5, 1, 0};
        vecs[2]  = '{1, 0, 8'h11, 0, 0, 1, 1, 8'h11, 2, 0};
        vecs[3]  = '{1, 0, 8'h22, 0, 0, 1, 1, 8'h11, 3, 1};
        vecs[4]  = '{1, 0, 8'h33, 0, 0, 0, 1, 8'h11, 3, 2};
        vecs[5]  = '{1, 0, 8'h33, 1, 0, 0, 1, 8'h22, 3, 2};
        vecs[6]  = '{1, 1, 8'h00, 1, 0, 0, 0, 8'h22, 3, 2};
        vecs[7]  = '{1, 0, 8'h44, 0, 0, 1, 1, 8'h44, 4, 2};
        vecs[8]  = '{0, 0, 8'h55, 0, 0, 0, 1, 8'h44, 4, 3};
        vecs[9]  = '{0, 0, 8'h55, 1, 0, 0, 0, 8'h44, 4, 3};
        vecs[10] = '{1, 0, 8'h55, 1, 0, 1, 1, 8'h55, 5, 3};
        vecs[11] = '{1, 0, 8'h66, 1, 0, 1, 1, 8'h66, 6, 3};
        vecs[12] = '{1, 0, 8'h77, 0, 0, 1, 1, 8'h66, 7, 4};
        vecs[13] = '{0, 0, 8'h88, 1, 0, 0, 1, 8'h77, 7, 4};
        vecs[14] = '{0, 1, 8'h00, 1, 0, 0, 0, 8'h77, 7, 4};
        vecs[15] = '{1, 1, 8'h00, 0, 1, 0, 0, 8'h77, 0, 0};

        en = 1; empty = 0; rdata = 8'h5A; out_ready = 0;
        #12;
        chk("rst_pop", pop, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pop_cnt", pop_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("rel_pop", pop, 1);
        @(posedge clk); #1;
        chk("rel_valid", out_valid, 1);
        chk("rel_data", out_data, 8'h5A);
        drive(1, 1, 0, 1, 0);
        @(posedge clk); #1;
        chk("rel_drain", out_valid, 0);
        drive(1, 1, 0, 1, 1);
        @(posedge clk); #1;
        chk("clr_pop_cnt", pop_cnt, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].empty, vecs[i].rdata, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d_pop", i), pop, vecs[i].pop);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].v);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].d);
            chk($sformatf("v%0d_pop_cnt", i), pop_cnt, vecs[i].pc);
            chk($sformatf("v%0d_stall_cnt", i), stall_cnt, vecs[i].sc);
        end

        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 8'hC0 + DW'(i), 0, 0);
            if (i >= 2) chk("sat_no_pop_two", pop, 0);
            @(posedge clk);
        end
        #1;
        chk("sat_stall", stall_cnt, 15);
        chk("sat_pop", pop_cnt, 2);
        chk("sat_head", out_data, 8'hC0);
        drive(1, 0, 8'hEE, 0, 1);
        @(posedge clk); #1;
        chk("clr_prio_stall", stall_cnt, 0);
        chk("clr_prio_pop", pop_cnt, 0);

        @(negedge clk); #3;
        reset_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_pop", pop, 0);
        @(negedge clk);
        empty = 1; out_ready = 0; reset_n = 1;

        begin
            logic [DW-1:0] q[$];
            logic          exp_pop;
            for (int c = 0; c < 400; c++) begin
                drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0),
                      DW'($urandom), 1'($urandom_range(0, 1)), 0);
                exp_pop = en & ~empty & (q.size() < 2);
                chk("rnd_pop", pop, exp_pop);
                chk("rnd_valid", out_valid, q.size() != 0);
                if (q.size() != 0) chk("rnd_data", out_data, q[0]);
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (exp_pop) q.push_back(rdata);
                @(posedge clk);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
